// File: rtl/tlc_param.sv
// Two-street traffic-light controller with min/max green dwell and optional
// protected left-turn phases.
// Build option: define TLC_LEFT_EN to compile in the S_AL/S_BL left-turn
// phases and their trailing yellows; otherwise the controller runs a plain
// four-phase sequence and treats those codes as illegal.
module tlc_param #(
    parameter int unsigned MIN_GREEN = 4,
    parameter int unsigned MAX_GREEN = 16,
    parameter int unsigned YELLOW_T  = 2,
    parameter int unsigned LEFT_T    = 3,
    parameter int unsigned CNT_W     = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       Ta,
    input  logic       Tb,
    output logic [1:0] La,
    output logic [1:0] Lb,
    output logic [2:0] state
);

    // Light codes
    localparam logic [1:0] L_GREEN  = 2'b00;
    localparam logic [1:0] L_YELLOW = 2'b01;
    localparam logic [1:0] L_RED    = 2'b11;
`ifdef TLC_LEFT_EN
    localparam logic [1:0] L_LEFT   = 2'b10;
`endif

    // Terminal counts of the dwell timer
    localparam logic [CNT_W-1:0] L_MIN_TC = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] L_MAX_TC = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] L_YEL_TC = CNT_W'(YELLOW_T - 1);
`ifdef TLC_LEFT_EN
    localparam logic [CNT_W-1:0] L_LFT_TC = CNT_W'(LEFT_T - 1);
`endif

    // Parameter legality: every terminal count must fit the timer
    localparam bit L_CFG_OK = (MIN_GREEN >= 1) && (MAX_GREEN >= MIN_GREEN) &&
                              (YELLOW_T >= 1) && (LEFT_T >= 1) &&
                              (CNT_W >= 1) && (CNT_W <= 31) &&
                              (MAX_GREEN <= (32'd1 << CNT_W)) &&
                              (YELLOW_T <= (32'd1 << CNT_W)) &&
                              (LEFT_T <= (32'd1 << CNT_W));

    generate
        if (!L_CFG_OK) begin : g_cfg_err
            $error("tlc_param: illegal parameter set");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_AG  = 3'd0,
        S_AY1 = 3'd1,
        S_AL  = 3'd2,
        S_AY2 = 3'd3,
        S_BG  = 3'd4,
        S_BY1 = 3'd5,
        S_BL  = 3'd6,
        S_BY2 = 3'd7
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             w_adv;
    logic             w_a_go;
    logic             w_b_go;
    logic             w_yel_done;

    // Green exit: minimum reached and street empty, or maximum reached
    assign w_a_go     = ((r_cnt >= L_MIN_TC) && !Ta) || (r_cnt >= L_MAX_TC);
    assign w_b_go     = ((r_cnt >= L_MIN_TC) && !Tb) || (r_cnt >= L_MAX_TC);
    assign w_yel_done = (r_cnt >= L_YEL_TC);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_AG;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Dwell timer: cleared on every phase entry, counts while the phase holds
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (w_adv) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Next-state logic; sensors are only looked at in the green phases
    always_comb begin
        w_state_nxt = r_state;
        w_adv       = 1'b0;
        case (r_state)
            S_AG: begin
                if (w_a_go) begin
                    w_state_nxt = S_AY1;
                    w_adv       = 1'b1;
                end
            end
            S_AY1: begin
                if (w_yel_done) begin
`ifdef TLC_LEFT_EN
                    w_state_nxt = S_AL;
`else
                    w_state_nxt = S_BG;
`endif
                    w_adv       = 1'b1;
                end
            end
`ifdef TLC_LEFT_EN
            S_AL: begin
                if (r_cnt >= L_LFT_TC) begin
                    w_state_nxt = S_AY2;
                    w_adv       = 1'b1;
                end
            end
            S_AY2: begin
                if (w_yel_done) begin
                    w_state_nxt = S_BG;
                    w_adv       = 1'b1;
                end
            end
`endif
            S_BG: begin
                if (w_b_go) begin
                    w_state_nxt = S_BY1;
                    w_adv       = 1'b1;
                end
            end
            S_BY1: begin
                if (w_yel_done) begin
`ifdef TLC_LEFT_EN
                    w_state_nxt = S_BL;
`else
                    w_state_nxt = S_AG;
`endif
                    w_adv       = 1'b1;
                end
            end
`ifdef TLC_LEFT_EN
            S_BL: begin
                if (r_cnt >= L_LFT_TC) begin
                    w_state_nxt = S_BY2;
                    w_adv       = 1'b1;
                end
            end
            S_BY2: begin
                if (w_yel_done) begin
                    w_state_nxt = S_AG;
                    w_adv       = 1'b1;
                end
            end
`endif
            default: begin
                // Unused codes recover to A green with a fresh timer
                w_state_nxt = S_AG;
                w_adv       = 1'b1;
            end
        endcase
    end

    // Moore light decode from the state register; unknown codes show all-red
    always_comb begin
        La = L_RED;
        Lb = L_RED;
        case (r_state)
            S_AG:  La = L_GREEN;
            S_AY1: La = L_YELLOW;
            S_BG:  Lb = L_GREEN;
            S_BY1: Lb = L_YELLOW;
`ifdef TLC_LEFT_EN
            S_AL:  La = L_LEFT;
            S_AY2: La = L_YELLOW;
            S_BL:  Lb = L_LEFT;
            S_BY2: Lb = L_YELLOW;
`endif
            default: begin
                La = L_RED;
                Lb = L_RED;
            end
        endcase
    end

    assign state = 3'(r_state);

endmodule
